next_pc_unit: RTL and testbench
===============================

# next_pc_unit

Next-PC selection stage directly upstream of the program counter register in the 5-stage pipeline. Each cycle it looks up the current PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and produces the next fetch address for the PC register. A late-resolved mispredict redirect overrides the prediction. A redirect that arrives while the PC is stalled is held until the PC accepts it.

## Interface
- ENTRIES, 16, BTB entries (power of two)
- IDX_W, 4, log2(ENTRIES)
- RESET_VECTOR, 32'h0000_0000, pc_o value while rst_i is high
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  same start qualifier the PC register receives
- hazard_i  in  1  stall to PC register; 1 = PC will not load this cycle
- pc_i  in  32  current PC (PC register output)
- pc_o  out  32  next PC (PC register input)
- pred_taken_o  out  1  prediction for the instruction at pc_i; travels down IF/ID
- redirect_i  in  1  mispredict detected in EX; fetch must restart at redirect_pc_i
- redirect_pc_i  in  32  correct next PC
- upd_valid_i  in  1  a resolved branch updates the BTB this cycle
- upd_pc_i  in  32  PC of the resolved branch
- upd_taken_i  in  1  actual branch outcome
- upd_target_i  in  32  actual branch target

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[31:IDX_W+2]. Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Lookup hit = valid && tag match at the index of pc_i.
- pred_taken_o = hit && ctr[1].
- pc_o priority:
  - rst_i → RESET_VECTOR.
  - Otherwise redirect_i → redirect_pc_i.
  - Otherwise pend_valid → pend_pc.
  - Otherwise pred_taken_o → target.
  - Otherwise pc_i + 4, modulo 2^32, so 32'hFFFF_FFFC yields 0.
- Accept condition: accept = start_i && !hazard_i.
- Pending redirect register (pend_valid, pend_pc):
  - redirect_i && !accept → set pend_valid, pend_pc = redirect_pc_i. A newer redirect overwrites an older pending one.
  - accept && !redirect_i → clear pend_valid.
  - redirect_i && accept → pend_valid cleared.
- BTB update when upd_valid_i is high:
  - Hit, taken → ctr saturating increment (11 stays 11), target = upd_target_i.
  - Hit, not taken → ctr saturating decrement (00 stays 00). Entry stays valid.
  - Miss, taken → allocate: valid = 1, tag, target, ctr = 10 (weakly taken). This replaces any entry at that index.
  - Miss, not taken → no change.
- Update and lookup to the same index in the same cycle: the lookup sees pre-update contents (read-before-write).
- Reset (synchronous):
  - All valid bits = 0, all ctr = 01, pend_valid = 0.
  - Target and tag arrays need not be reset.
  - pred_taken_o = 0 while rst_i is high.
  - Reset mid-redirect discards the pending redirect.

## Timing
- Lookup and pc_o are combinational from pc_i, redirect_i and state, with zero-cycle latency. The PC register loads pc_o at the next edge.
- A BTB update is visible to lookups from the cycle after upd_valid_i.
- A pending redirect is presented on pc_o from the cycle after capture. It remains until the first accept cycle and is cleared at that edge.
- No handshake on the update port: one update per cycle, always accepted.
- Inputs redirect_i and upd_valid_i are independent and may coincide.

## Structure
- The shared package holds:
  - counter encodings: CTR_SNT = 2'b00, CTR_WNT = 2'b01, CTR_WT = 2'b10, CTR_ST = 2'b11
  - PC_INC = 32'd4
  - the BTB entry struct (valid, tag, target, ctr)
- One sub-module, btb_array, holds the storage. It provides:
  - a combinational read port
  - a synchronous write port
  - synchronous valid/ctr reset
- next_pc_unit contains the counter update logic, the pending-redirect register and the pc_o mux.

## Test plan
- Reset, then pc_i = 0x100, no updates → pc_o = 0x104, pred_taken_o = 0. While rst_i is high, pc_o = 0x0.
- Update pc 0x100 taken → 0x200. Next cycle pc_i = 0x100 → pc_o = 0x200, pred_taken_o = 1. Then 1× not-taken update → ctr = 01, pc_o = 0x104.
- Four taken updates, then 1 not-taken → ctr = 10, still predicts taken. pc 0x140 aliases index 0 with a different tag → miss, pc_o = 0x144.
- redirect_i = 1, redirect_pc_i = 0x300, hazard_i = 1 for 3 cycles → pc_o = 0x300 for all 3 cycles. On the first cycle with hazard_i = 0, the PC loads 0x300 and pend_valid clears.
- Same-cycle update and lookup on index of 0x180, taken, 0x400, starting from an empty table → that cycle pc_o = 0x184; the next cycle pc_o = 0x400.
- pc_i = 0xFFFF_FFFC with no hit → pc_o = 0x0000_0000. Reset asserted with a redirect pending → pend_valid = 0 after the edge.

Source files
------------

// File: rtl/next_pc_unit_pkg.sv
// Shared types and constants for the next-PC selection stage and its BTB.
package next_pc_unit_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [31:0] PC_INC = 32'd4;

  // Tag is held zero-extended to 32 bits; the upper unused bits stay constant.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != CTR_ST) res = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) res = ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/next_pc_unit_btb_array.sv
// Direct-mapped BTB storage: two combinational read ports, one synchronous write port.
module btb_array
  import next_pc_unit_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  output btb_entry_t       lk_entry,
  input  logic [IDX_W-1:0] up_idx,
  output btb_entry_t       up_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  logic        valid_q  [ENTRIES];
  logic [1:0]  ctr_q    [ENTRIES];
  logic [31:0] tag_q    [ENTRIES];
  logic [31:0] target_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
      ctr_q[wr_idx]   <= wr_entry.ctr;
    end
  end

  // Tag and target carry no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  always_comb begin
    lk_entry.valid  = valid_q[lk_idx];
    lk_entry.tag    = tag_q[lk_idx];
    lk_entry.target = target_q[lk_idx];
    lk_entry.ctr    = ctr_q[lk_idx];
    up_entry.valid  = valid_q[up_idx];
    up_entry.tag    = tag_q[up_idx];
    up_entry.target = target_q[up_idx];
    up_entry.ctr    = ctr_q[up_idx];
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC selection: BTB prediction, mispredict redirect and a held redirect for stalled PCs.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int          ENTRIES      = 16,
  parameter int          IDX_W        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        hazard_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [31:0]      lk_tag, up_tag;
  btb_entry_t       lk_entry, up_entry, wr_entry;
  logic             lk_hit, up_hit, wr_en;
  logic             accept;
  logic             pend_valid;
  logic [31:0]      pend_pc;

  assign lk_idx = pc_i[IDX_W+1:2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign lk_tag = pc_i >> (IDX_W + 2);
  assign up_tag = upd_pc_i >> (IDX_W + 2);

  btb_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_btb (
    .clk      (clk_i),
    .rst      (rst_i),
    .lk_idx   (lk_idx),
    .lk_entry (lk_entry),
    .up_idx   (up_idx),
    .up_entry (up_entry),
    .wr_en    (wr_en),
    .wr_idx   (up_idx),
    .wr_entry (wr_entry)
  );

  assign lk_hit       = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign up_hit       = up_entry.valid && (up_entry.tag == up_tag);
  // Array valids only clear at the reset edge, so gate the prediction while reset is held.
  assign pred_taken_o = !rst_i && lk_hit && lk_entry.ctr[1];
  assign accept       = start_i && !hazard_i;

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = up_entry;
    if (upd_valid_i) begin
      if (up_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_next(up_entry.ctr, upd_taken_i);
        if (upd_taken_i) wr_entry.target = upd_target_i;
      end else if (upd_taken_i) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = up_tag;
        wr_entry.target = upd_target_i;
        wr_entry.ctr    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
      pend_pc    <= RESET_VECTOR;
    end else if (redirect_i && !accept) begin
      pend_valid <= 1'b1;
      pend_pc    <= redirect_pc_i;
    end else if (accept) begin
      pend_valid <= 1'b0;
    end
  end

  always_comb begin
    pc_o = pc_i + PC_INC;
    if (rst_i)             pc_o = RESET_VECTOR;
    else if (redirect_i)   pc_o = redirect_pc_i;
    else if (pend_valid)   pc_o = pend_pc;
    else if (pred_taken_o) pc_o = lk_entry.target;
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed test-plan sequence then random traffic, checked against an array-based model.
module tb_next_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, hazard_i, redirect_i, upd_valid_i, upd_taken_i;
  logic [31:0] pc_i, redirect_pc_i, upd_pc_i, upd_target_i;
  logic [31:0] pc_o;
  logic        pred_taken_o;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  bit          m_pend;
  logic [31:0] m_pend_pc;

  always #5 clk_i = ~clk_i;

  next_pc_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .hazard_i      (hazard_i),
    .pc_i          (pc_i),
    .pc_o          (pc_o),
    .pred_taken_o  (pred_taken_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit model_pred();
    int i;
    i = idx_of(pc_i);
    return !rst_i && m_valid[i] && m_tag[i] == tag_of(pc_i) && m_ctr[i] >= 2;
  endfunction

  function automatic logic [31:0] model_pc();
    logic [31:0] nxt;
    nxt = pc_i + 32'd4;
    if (rst_i)             return 32'h0;
    if (redirect_i)        return redirect_pc_i;
    if (m_pend)            return m_pend_pc;
    if (model_pred())      return m_target[idx_of(pc_i)];
    return nxt;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int i;
    bit hit, accept;
    if (rst_i) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 1;
      end
      m_pend = 0;
      return;
    end
    accept = start_i && !hazard_i;
    if (redirect_i && !accept) begin
      m_pend    = 1;
      m_pend_pc = redirect_pc_i;
    end else if (accept) m_pend = 0;
    if (upd_valid_i) begin
      i   = idx_of(upd_pc_i);
      hit = m_valid[i] && m_tag[i] == tag_of(upd_pc_i);
      if (hit && upd_taken_i) begin
        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_target[i] = upd_target_i;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (upd_taken_i) begin
        m_valid[i]  = 1;
        m_tag[i]    = tag_of(upd_pc_i);
        m_target[i] = upd_target_i;
        m_ctr[i]    = 2;
      end
    end
  endtask

  // Inputs are already set; sample mid-cycle, compare, then commit model state.
  task automatic cycle(input bit use_lit, input logic [31:0] lit_pc, input logic lit_pred);
    #1;
    check("pc_o", pc_o, model_pc());
    check("pred_taken_o", {31'b0, pred_taken_o}, {31'b0, model_pred()});
    if (use_lit) begin
      check("plan_pc_o", pc_o, lit_pc);
      check("plan_pred", {31'b0, pred_taken_o}, {31'b0, lit_pred});
    end
    model_step();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    rst_i = 0; start_i = 1; hazard_i = 0; redirect_i = 0; redirect_pc_i = 0;
    upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0; upd_target_i = 0;
  endtask

  task automatic set_upd(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
    upd_valid_i = 1; upd_pc_i = upc; upd_taken_i = tk; upd_target_i = tgt;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    idle_inputs();
    rst_i = 1; pc_i = pc;
    cycle(1, 32'h0, 1'b0);
    cycle(1, 32'h0, 1'b0);
    rst_i = 0;
  endtask

  initial begin
    m_pend = 0; m_pend_pc = 0;
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 0; m_ctr[k] = 1; m_tag[k] = 0; m_target[k] = 0;
    end
    idle_inputs();
    pc_i = 32'h100;
    @(negedge clk_i);

    do_reset(32'h100);
    cycle(1, 32'h104, 1'b0);
    set_upd(32'h100, 1, 32'h200);
    cycle(1, 32'h104, 1'b0);
    idle_inputs();
    cycle(1, 32'h200, 1'b1);
    set_upd(32'h100, 0, 32'h0);
    cycle(1, 32'h200, 1'b1);
    idle_inputs();
    cycle(1, 32'h104, 1'b0);

    for (int k = 0; k < 4; k++) begin
      set_upd(32'h100, 1, 32'h200);
      cycle(0, 32'h0, 1'b0);
    end
    set_upd(32'h100, 0, 32'h0);
    cycle(0, 32'h0, 1'b0);
    idle_inputs();
    cycle(1, 32'h200, 1'b1);
    pc_i = 32'h140;
    cycle(1, 32'h144, 1'b0);

    pc_i = 32'h200; hazard_i = 1; redirect_i = 1; redirect_pc_i = 32'h300;
    cycle(1, 32'h300, 1'b0);
    redirect_i = 0; redirect_pc_i = 32'h0;
    cycle(1, 32'h300, 1'b0);
    cycle(1, 32'h300, 1'b0);
    hazard_i = 0;
    cycle(1, 32'h300, 1'b0);
    pc_i = 32'h300;
    cycle(1, 32'h304, 1'b0);

    do_reset(32'h180);
    set_upd(32'h180, 1, 32'h400);
    cycle(1, 32'h184, 1'b0);
    idle_inputs();
    cycle(1, 32'h400, 1'b1);

    pc_i = 32'hFFFF_FFFC;
    cycle(1, 32'h0, 1'b0);

    pc_i = 32'h20; hazard_i = 1; redirect_i = 1; redirect_pc_i = 32'h500;
    cycle(1, 32'h500, 1'b0);
    redirect_i = 0; redirect_pc_i = 0;
    cycle(1, 32'h500, 1'b0);
    rst_i = 1;
    cycle(1, 32'h0, 1'b0);
    rst_i = 0;
    cycle(1, 32'h24, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      rst_i         = ($urandom_range(0, 199) == 0);
      start_i       = ($urandom_range(0, 9) != 0);
      hazard_i      = ($urandom_range(0, 2) == 0);
      redirect_i    = ($urandom_range(0, 5) == 0);
      redirect_pc_i = $urandom() & 32'hFFFF_FFFC;
      pc_i          = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC
                      : ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
      upd_valid_i   = $urandom_range(0, 1) == 1;
      upd_pc_i      = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      upd_taken_i   = $urandom_range(0, 2) != 0;
      upd_target_i  = $urandom() & 32'hFFFF_FFFC;
      cycle(0, 32'h0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
